dmem_wb_arbiter: RTL and testbench

//  Two-master Wishbone arbiter/sequencer in front of the single-port data memory.

---
 rtl/dmem_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_wb_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wb_arbiter.sv
// dmem_wb_arbiter
//   Two-master Wishbone arbiter/sequencer in front of the single-port data
//   memory. Master 0 is the core LSU, master 1 is the JTAG debug/DMA port.
//   The memory acks in the strobe cycle and returns read data one cycle
//   later; each access is sequenced IDLE -> ACCESS -> RESP so that the
//   master's ack lines up with that late read data.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   mN_cyc_i/stb_i      master N request (N = 0,1)
//   mN_adr_i/we_i/sel_i/dat_i  master N byte address, write enable, lanes, write data
//   mN_dat_o/ack_o      master N read data (valid with ack) and one-cycle ack
//   s_cyc_o/stb_o/adr_o/we_o/sel_o/dat_o  memory request, driven from latches
//   s_dat_i/s_ack_i     memory read data (cycle after ack) and ack
//   gnt_o               one-hot current owner, 00 when idle
//   busy_o              high in any state other than IDLE
module dmem_wb_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned RR_MODE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [AW-1:0]     s_adr_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  logic       last_gnt;   // index of the most recent owner
  logic [1:0] gnt;
  logic       req0;
  logic       req1;
  logic       win;        // index of the master that wins in IDLE
  logic       in_resp;

  always_comb begin
    req0 = m0_cyc_i & m0_stb_i;
    req1 = m1_cyc_i & m1_stb_i;
    if (req0 && req1) begin
      if (RR_MODE != 0) win = ~last_gnt;
      else              win = 1'b0;
    end else begin
      win = req1;
    end
  end

  // The memory-side outputs are the latches themselves, so nothing a master
  // does after winning can reach the memory until the next IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= '0;
      s_cyc_o  <= 1'b0;
      s_stb_o  <= 1'b0;
      s_adr_o  <= '0;
      s_we_o   <= 1'b0;
      s_sel_o  <= '0;
      s_dat_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt     <= win ? 2'b10 : 2'b01;
            s_adr_o <= win ? m1_adr_i : m0_adr_i;
            s_we_o  <= win ? m1_we_i  : m0_we_i;
            s_sel_o <= win ? m1_sel_i : m0_sel_i;
            s_dat_o <= win ? m1_dat_i : m0_dat_i;
            s_cyc_o <= 1'b1;
            s_stb_o <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (s_ack_i) begin
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          last_gnt <= gnt[1];
          gnt      <= '0;
          state    <= IDLE;
        end
        default: begin
          gnt     <= '0;
          s_cyc_o <= 1'b0;
          s_stb_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Read data arrives from the memory during RESP, so the master-side data
  // is steered combinationally from s_dat_i; the ack is withheld from a
  // master that has dropped cyc, though its memory access has happened.
  always_comb begin
    in_resp  = (state == RESP);
    m0_ack_o = in_resp & gnt[0] & m0_cyc_i;
    m1_ack_o = in_resp & gnt[1] & m1_cyc_i;
    m0_dat_o = (in_resp && gnt[0]) ? s_dat_i : '0;
    m1_dat_o = (in_resp && gnt[1]) ? s_dat_i : '0;
    gnt_o    = gnt;
    busy_o   = (state != IDLE);
  end

endmodule

// File: tb/tb_dmem_wb_arbiter.sv
module tb_dmem_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  typedef struct packed {
    logic        m;
    logic        we;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Master-side stimulus, indexed [instance][master]; instance 0 is
  // round-robin, instance 1 is fixed priority.
  logic        m_cyc  [2][2];
  logic        m_stb  [2][2];
  logic        m_we   [2][2];
  logic [3:0]  m_sel  [2][2];
  logic [31:0] m_adr  [2][2];
  logic [31:0] m_wdat [2][2];

  logic [31:0] r_m0_dat, r_m1_dat, r_s_adr, r_s_dat, r_s_rdat;
  logic        r_m0_ack, r_m1_ack, r_s_cyc, r_s_stb, r_s_we, r_s_ack, r_busy;
  logic [3:0]  r_s_sel;
  logic [1:0]  r_gnt;
  logic [31:0] f_m0_dat, f_m1_dat, f_s_adr, f_s_dat, f_s_rdat;
  logic        f_m0_ack, f_m1_ack, f_s_cyc, f_s_stb, f_s_we, f_s_ack, f_busy;
  logic [3:0]  f_s_sel;
  logic [1:0]  f_gnt;

  dmem_wb_arbiter #(.AW(32), .DW(32), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m_cyc[0][0]), .m0_stb_i(m_stb[0][0]), .m0_adr_i(m_adr[0][0]),
    .m0_we_i(m_we[0][0]), .m0_sel_i(m_sel[0][0]), .m0_dat_i(m_wdat[0][0]),
    .m0_dat_o(r_m0_dat), .m0_ack_o(r_m0_ack),
    .m1_cyc_i(m_cyc[0][1]), .m1_stb_i(m_stb[0][1]), .m1_adr_i(m_adr[0][1]),
    .m1_we_i(m_we[0][1]), .m1_sel_i(m_sel[0][1]), .m1_dat_i(m_wdat[0][1]),
    .m1_dat_o(r_m1_dat), .m1_ack_o(r_m1_ack),
    .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb), .s_adr_o(r_s_adr), .s_we_o(r_s_we),
    .s_sel_o(r_s_sel), .s_dat_o(r_s_dat), .s_dat_i(r_s_rdat), .s_ack_i(r_s_ack),
    .gnt_o(r_gnt), .busy_o(r_busy)
  );

  dmem_wb_arbiter #(.AW(32), .DW(32), .RR_MODE(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m_cyc[1][0]), .m0_stb_i(m_stb[1][0]), .m0_adr_i(m_adr[1][0]),
    .m0_we_i(m_we[1][0]), .m0_sel_i(m_sel[1][0]), .m0_dat_i(m_wdat[1][0]),
    .m0_dat_o(f_m0_dat), .m0_ack_o(f_m0_ack),
    .m1_cyc_i(m_cyc[1][1]), .m1_stb_i(m_stb[1][1]), .m1_adr_i(m_adr[1][1]),
    .m1_we_i(m_we[1][1]), .m1_sel_i(m_sel[1][1]), .m1_dat_i(m_wdat[1][1]),
    .m1_dat_o(f_m1_dat), .m1_ack_o(f_m1_ack),
    .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_adr_o(f_s_adr), .s_we_o(f_s_we),
    .s_sel_o(f_s_sel), .s_dat_o(f_s_dat), .s_dat_i(f_s_rdat), .s_ack_i(f_s_ack),
    .gnt_o(f_gnt), .busy_o(f_busy)
  );

  // Memory behind the round-robin instance: acks after 'stall' wait cycles,
  // registered read data, byte-lane writes.
  logic [31:0] mem [16] = '{default: '0};
  int unsigned stall = 0;
  int unsigned wcnt;
  assign r_s_ack = r_s_cyc & r_s_stb & (wcnt == stall);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt <= 0;
    else if (r_s_cyc && r_s_stb) begin
      if (r_s_ack) begin
        wcnt <= 0;
        r_s_rdat <= mem[r_s_adr[5:2]];
        if (r_s_we)
          for (int b = 0; b < 4; b++)
            if (r_s_sel[b]) mem[r_s_adr[5:2]][b*8 +: 8] <= r_s_dat[b*8 +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Read-only memory behind the fixed-priority instance: word depends on address.
  function automatic logic [31:0] fp_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction
  assign f_s_ack = f_s_cyc & f_s_stb;
  always @(posedge clk) if (f_s_ack) f_s_rdat <= fp_word(f_s_adr);

  // Reference model and scoreboard
  logic [31:0] ref_mem [16] = '{default: '0};
  logic        ref_last [2];
  exp_t        q_rr[$];
  exp_t        q_fp[$];
  txn_t        stim [2][2][8];
  int          stim_n [2][2];
  int          last_wait [2][2];
  int          ack_cnt [2][2];
  logic [31:0] last_rdat [2][2];
  logic [15:0] ord_bits [2];
  int          compared = 0;
  int          mism = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mism++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic txn_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] dat);
    txn_t t;
    t.we = we; t.sel = sel; t.adr = adr; t.dat = dat;
    return t;
  endfunction

  function automatic void ref_apply(input int inst, input int m, input txn_t t, input bit want_ack);
    exp_t e;
    logic [31:0] w;
    e.m = m[0];
    e.we = t.we;
    e.dat = '0;
    if (inst == 0) begin
      w = ref_mem[t.adr[5:2]];
      if (t.we) begin
        for (int b = 0; b < 4; b++) if (t.sel[b]) w[b*8 +: 8] = t.dat[b*8 +: 8];
        ref_mem[t.adr[5:2]] = w;
      end else begin
        e.dat = w;
      end
      if (want_ack) q_rr.push_back(e);
    end else begin
      e.dat = fp_word(t.adr);
      if (want_ack) q_fp.push_back(e);
    end
  endfunction

  // Order of service for one round in which both masters present their
  // lists together and each re-requests right after every ack.
  function automatic void plan_round(input int inst);
    int i[2];
    int w;
    i = '{0, 0};
    while (i[0] < stim_n[inst][0] || i[1] < stim_n[inst][1]) begin
      if (i[0] < stim_n[inst][0] && i[1] < stim_n[inst][1])
        w = (inst == 0) ? (ref_last[inst] ? 0 : 1) : 0;
      else
        w = (i[0] < stim_n[inst][0]) ? 0 : 1;
      ref_apply(inst, w, stim[inst][w][i[w]], 1'b1);
      ref_last[inst] = w[0];
      i[w]++;
    end
  endfunction

  function automatic logic ack_of(input int inst, input int n);
    if (inst == 0) return (n == 0) ? r_m0_ack : r_m1_ack;
    return (n == 0) ? f_m0_ack : f_m1_ack;
  endfunction

  task automatic run_master(input int inst, input int n);
    int w;
    for (int k = 0; k < stim_n[inst][n]; k++) begin
      m_cyc[inst][n]  = 1'b1;
      m_stb[inst][n]  = 1'b1;
      m_we[inst][n]   = stim[inst][n][k].we;
      m_sel[inst][n]  = stim[inst][n][k].sel;
      m_adr[inst][n]  = stim[inst][n][k].adr;
      m_wdat[inst][n] = stim[inst][n][k].dat;
      w = 0;
      do begin @(negedge clk); w++; end while (!ack_of(inst, n) && w < 40);
      last_wait[inst][n] = w;
      if (!ack_of(inst, n)) begin
        compared++; mism++;
        $display("FAIL ack_timeout: inst%0d m%0d got no ack in %0d cycles, required an ack", inst, n, w);
      end
      @(posedge clk); #1;
    end
    m_cyc[inst][n] = 1'b0;
    m_stb[inst][n] = 1'b0;
  endtask

  task automatic run_round(input int inst);
    plan_round(inst);
    fork
      run_master(inst, 0);
      run_master(inst, 1);
    join
  endtask

  task automatic rand_round(input int inst);
    for (int n = 0; n < 2; n++) begin
      stim_n[inst][n] = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++)
        stim[inst][n][k] = mk((inst == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                              4'($urandom_range(1, 15)),
                              {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
    end
    run_round(inst);
  endtask

  task automatic mon_check(input int inst, input logic a0, input logic a1,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] g);
    exp_t e;
    logic am;
    if (!(a0 || a1)) return;
    am = a1;
    ack_cnt[inst][am]++;
    ord_bits[inst] = {ord_bits[inst][14:0], am};
    chk("single_ack", 32'(a0 & a1), 32'd0);
    if ((inst == 0 && q_rr.size() == 0) || (inst == 1 && q_fp.size() == 0)) begin
      compared++; mism++;
      $display("FAIL unexpected_ack: inst%0d m%0d acked, required no ack", inst, am);
      return;
    end
    if (inst == 0) e = q_rr.pop_front();
    else           e = q_fp.pop_front();
    chk("ack_owner", 32'(am), 32'(e.m));
    chk("gnt_during_ack", 32'(g), am ? 32'd2 : 32'd1);
    if (!e.we) chk("read_data", am ? d1 : d0, e.dat);
    chk("other_dat_zero", am ? d0 : d1, 32'd0);
    last_rdat[inst][am] = am ? d1 : d0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon_check(0, r_m0_ack, r_m1_ack, r_m0_dat, r_m1_dat, r_gnt);
      mon_check(1, f_m0_ack, f_m1_ack, f_m0_dat, f_m1_dat, f_gnt);
    end
  end

  task automatic check_reset_outputs();
    chk("rst_rr_slave_ctl", 32'({r_s_cyc, r_s_stb, r_s_we, r_s_sel}), 32'd0);
    chk("rst_rr_s_adr", r_s_adr, 32'd0);
    chk("rst_rr_s_dat", r_s_dat, 32'd0);
    chk("rst_rr_master_ctl", 32'({r_m0_ack, r_m1_ack, r_gnt, r_busy}), 32'd0);
    chk("rst_rr_m0_dat", r_m0_dat, 32'd0);
    chk("rst_rr_m1_dat", r_m1_dat, 32'd0);
    chk("rst_fp_ctl", 32'({f_s_cyc, f_s_stb, f_m0_ack, f_m1_ack, f_gnt, f_busy}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [31:0] wd;
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 2; n++) begin
        m_cyc[i][n] = 1'b0; m_stb[i][n] = 1'b0; m_we[i][n] = 1'b0;
        m_sel[i][n] = '0; m_adr[i][n] = '0; m_wdat[i][n] = '0;
        stim_n[i][n] = 0; ack_cnt[i][n] = 0; last_rdat[i][n] = '0; last_wait[i][n] = 0;
      end
    ord_bits[0] = '0; ord_bits[1] = '0;
    ref_last[0] = 1'b1; ref_last[1] = 1'b1;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back by master 0, with latency check.
    stim[0][0][0] = mk(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    stim_n[0][0] = 1; stim_n[0][1] = 0;
    run_round(0);
    stim[0][0][0] = mk(1'b0, 4'hF, 32'h10, 32'h0);
    run_round(0);
    chk("read_latency_T2", 32'(last_wait[0][0]), 32'd3);
    chk("m0_read_deadbeef", last_rdat[0][0], 32'hDEADBEEF);

    // Byte-lane write from master 1.
    stim[0][1][0] = mk(1'b1, 4'h2, 32'h10, 32'h0000AB00);
    stim_n[0][0] = 0; stim_n[0][1] = 1;
    run_round(0);
    stim[0][0][0] = mk(1'b0, 4'hF, 32'h10, 32'h0);
    stim_n[0][0] = 1; stim_n[0][1] = 0;
    run_round(0);
    chk("byte_lane_merge", last_rdat[0][0], 32'hDEADABEF);

    for (int r = 0; r < 10; r++) rand_round(0);

    // Contention: master 1 owns last so master 0 opens the alternation.
    stim[0][1][0] = mk(1'b0, 4'hF, 32'h0, 32'h0);
    stim_n[0][0] = 0; stim_n[0][1] = 1;
    run_round(0);
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++)
        stim[0][n][k] = mk(1'b0, 4'hF, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, 32'h0);
    stim_n[0][0] = 4; stim_n[0][1] = 4;
    ord_bits[0] = '0;
    run_round(0);
    chk("rr_grant_order", 32'(ord_bits[0][7:0]), 32'h55);

    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++)
        stim[1][n][k] = mk(1'b0, 4'hF, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, 32'h0);
    stim_n[1][0] = 4; stim_n[1][1] = 4;
    ord_bits[1] = '0;
    run_round(1);
    chk("fp_grant_order", 32'(ord_bits[1][7:0]), 32'h0F);
    for (int r = 0; r < 5; r++) rand_round(1);

    // Abort: master 1 drops cyc during ACCESS of a write.
    wd = $urandom;
    ref_apply(0, 1, mk(1'b1, 4'hF, 32'h20, wd), 1'b0);
    ref_last[0] = 1'b1;
    w = ack_cnt[0][1];
    m_cyc[0][1] = 1'b1; m_stb[0][1] = 1'b1; m_we[0][1] = 1'b1;
    m_sel[0][1] = 4'hF; m_adr[0][1] = 32'h20; m_wdat[0][1] = wd;
    @(posedge clk); #1;
    m_cyc[0][1] = 1'b0; m_stb[0][1] = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("abort_no_ack", 32'(ack_cnt[0][1] - w), 32'd0);
    stim[0][0][0] = mk(1'b0, 4'hF, 32'h20, 32'h0);
    stim_n[0][0] = 1; stim_n[0][1] = 0;
    run_round(0);
    chk("abort_write_committed", last_rdat[0][0], wd);

    // Slow memory: three wait cycles, master inputs change underneath.
    stall = 3;
    wd = $urandom;
    ref_apply(0, 0, mk(1'b1, 4'hF, 32'h24, wd), 1'b1);
    ref_last[0] = 1'b0;
    m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1; m_we[0][0] = 1'b1;
    m_sel[0][0] = 4'hF; m_adr[0][0] = 32'h24; m_wdat[0][0] = wd;
    @(posedge clk); #1;
    m_we[0][0] = 1'b0; m_sel[0][0] = 4'h1; m_adr[0][0] = 32'h3C; m_wdat[0][0] = ~wd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("slow_stb_held", 32'(r_s_stb & r_s_cyc), 32'd1);
      chk("slow_adr_stable", r_s_adr, 32'h24);
      chk("slow_dat_stable", r_s_dat, wd);
      chk("slow_ctl_stable", 32'({r_s_we, r_s_sel}), 32'h1F);
    end
    w = 0;
    do begin @(negedge clk); w++; end while (!r_m0_ack && w < 10);
    chk("slow_ack_seen", 32'(r_m0_ack), 32'd1);
    @(posedge clk); #1;
    m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
    stall = 0;
    stim[0][1][0] = mk(1'b0, 4'hF, 32'h24, 32'h0);
    stim_n[0][0] = 0; stim_n[0][1] = 1;
    run_round(0);
    chk("slow_write_readback", last_rdat[0][1], wd);

    // Reset while in ACCESS, then the first tie goes to master 0.
    m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1; m_we[0][0] = 1'b0;
    m_sel[0][0] = 4'hF; m_adr[0][0] = 32'h10;
    w = 0;
    do begin @(negedge clk); w++; end while (!r_s_stb && w < 10);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
    ref_last[0] = 1'b1; ref_last[1] = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    stim[0][0][0] = mk(1'b0, 4'hF, 32'h10, 32'h0);
    stim[0][1][0] = mk(1'b0, 4'hF, 32'h24, 32'h0);
    stim_n[0][0] = 1; stim_n[0][1] = 1;
    ord_bits[0] = '0;
    run_round(0);
    chk("tie_after_reset", 32'(ord_bits[0][1:0]), 32'h1);

    for (int r = 0; r < 15; r++) begin
      stall = $urandom_range(0, 2);
      rand_round(0);
    end
    stall = 0;

    repeat (4) @(posedge clk);
    chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
    chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
